// File: rtl/chacha_keystream.sv
// ChaCha keystream generator with an Avalon-MM register file and Avalon-ST in/out.
// Runs ROUNDS/RPC step cycles per 512-bit block while the pad counter is non-zero.
module chacha_keystream #(
   parameter int ROUNDS = 20,
   parameter int RPC    = 1
) (
   input  logic         clock,
   input  logic         reset,
   input  logic         csr_write,
   input  logic         csr_read,
   input  logic [4:0]   csr_address,
   input  logic [31:0]  csr_writedata,
   output logic [31:0]  csr_readdata,
   input  logic [511:0] snk_data,
   input  logic         snk_valid,
   output logic         snk_ready,
   output logic [511:0] st_data,
   output logic         st_valid,
   input  logic         st_ready
);

   typedef logic [15:0][31:0] state_t;

   localparam logic [4:0]  LAST_ROUND = 5'(ROUNDS - RPC);
   localparam logic [4:0]  ROUND_STEP = 5'(RPC);
   localparam logic [31:0] UNMAPPED   = 32'hfb7e03d9;

   state_t        init_state_r;
   state_t        block_init_r;
   state_t        working_r;
   logic [31:0]   pad_counter_r;
   logic [4:0]    round_r;
   logic          xor_mode_r;
   logic          ctr64_r;
   logic          st_valid_r;
   logic [511:0]  st_data_r;
   logic [31:0]   csr_readdata_r;

   logic          run_s;
   logic          at_last_s;
   logic          final_s;
   logic          step_s;
   logic          step0_s;
   state_t        round_in_s;
   state_t        round_out_s;
   state_t        keystream_s;
   logic [31:0]   rd_s;

   function automatic logic [31:0] rotl(input logic [31:0] x, input logic [4:0] n);
      return (x << n) | (x >> (6'd32 - {1'b0, n}));
   endfunction

   function automatic state_t qr_at(input state_t s, input logic [3:0] ia, input logic [3:0] ib,
                                    input logic [3:0] ic, input logic [3:0] id);
      logic [31:0] a, b, c, d;
      state_t      r;
      a = s[ia];
      b = s[ib];
      c = s[ic];
      d = s[id];
      a = a + b;  d = rotl(d ^ a, 5'd16);
      c = c + d;  b = rotl(b ^ c, 5'd12);
      a = a + b;  d = rotl(d ^ a, 5'd8);
      c = c + d;  b = rotl(b ^ c, 5'd7);
      r     = s;
      r[ia] = a;
      r[ib] = b;
      r[ic] = c;
      r[id] = d;
      return r;
   endfunction

   function automatic state_t column_round(input state_t s);
      state_t t;
      t = qr_at(s, 4'd0, 4'd4, 4'd8,  4'd12);
      t = qr_at(t, 4'd1, 4'd5, 4'd9,  4'd13);
      t = qr_at(t, 4'd2, 4'd6, 4'd10, 4'd14);
      t = qr_at(t, 4'd3, 4'd7, 4'd11, 4'd15);
      return t;
   endfunction

   function automatic state_t diagonal_round(input state_t s);
      state_t t;
      t = qr_at(s, 4'd0, 4'd5, 4'd10, 4'd15);
      t = qr_at(t, 4'd1, 4'd6, 4'd11, 4'd12);
      t = qr_at(t, 4'd2, 4'd7, 4'd8,  4'd13);
      t = qr_at(t, 4'd3, 4'd4, 4'd9,  4'd14);
      return t;
   endfunction

   // With RPC=2 the round index is always even, so one step is a full double round.
   function automatic state_t do_step(input state_t s, input logic odd);
      if (RPC == 2) begin
         return diagonal_round(column_round(s));
      end else if (odd) begin
         return diagonal_round(s);
      end else begin
         return column_round(s);
      end
   endfunction

   // Engine control: a CSR write or reset freezes everything for that cycle.
   always_comb begin
      run_s       = !reset && !csr_write && (pad_counter_r != 32'd0);
      at_last_s   = (round_r == LAST_ROUND);
      final_s     = run_s && at_last_s && (!st_valid_r || st_ready) && (!xor_mode_r || snk_valid);
      step_s      = run_s && !at_last_s;
      step0_s     = step_s && (round_r == 5'd0);
      round_in_s  = (round_r == 5'd0) ? init_state_r : working_r;
      round_out_s = do_step(round_in_s, round_r[0]);
      keystream_s = '0;
      for (int i = 0; i < 16; i++) begin
         keystream_s[i[3:0]] = round_out_s[i[3:0]] + block_init_r[i[3:0]];
      end
   end

   // CSR read mux.
   always_comb begin
      rd_s = UNMAPPED;
      if (!csr_address[4]) begin
         rd_s = init_state_r[csr_address[3:0]];
      end else begin
         case (csr_address)
            5'd16:   rd_s = pad_counter_r;
            5'd17:   rd_s = {23'd0, (pad_counter_r != 32'd0), 3'd0, round_r};
            5'd18:   rd_s = {30'd0, ctr64_r, xor_mode_r};
            default: rd_s = UNMAPPED;
         endcase
      end
   end

   // Resettable control state: pad counter, round index, mode bits, output valid.
   always_ff @(posedge clock) begin
      if (reset) begin
         pad_counter_r <= 32'd0;
         round_r       <= 5'd0;
         xor_mode_r    <= 1'b0;
         ctr64_r       <= 1'b0;
         st_valid_r    <= 1'b0;
      end else if (csr_write) begin
         if (csr_address == 5'd16) begin
            pad_counter_r <= csr_writedata;
            round_r       <= 5'd0;
         end
         if (csr_address == 5'd18) begin
            xor_mode_r <= csr_writedata[0];
            ctr64_r    <= csr_writedata[1];
         end
      end else if (final_s) begin
         st_valid_r    <= 1'b1;
         pad_counter_r <= pad_counter_r - 32'd1;
         round_r       <= 5'd0;
      end else begin
         if (st_ready) begin
            st_valid_r <= 1'b0;
         end
         if (step_s) begin
            round_r <= round_r + ROUND_STEP;
         end
      end
   end

   // Datapath registers; these deliberately keep their contents through reset.
   always_ff @(posedge clock) begin
      if (csr_write && !csr_address[4]) begin
         init_state_r[csr_address[3:0]] <= csr_writedata;
      end else if (step0_s) begin
         init_state_r[12] <= init_state_r[12] + 32'd1;
         if (ctr64_r && (init_state_r[12] == 32'hffffffff)) begin
            init_state_r[13] <= init_state_r[13] + 32'd1;
         end
      end
      if (step0_s) begin
         block_init_r <= init_state_r;
      end
      if (step_s || final_s) begin
         working_r <= round_out_s;
      end
      if (final_s) begin
         st_data_r <= keystream_s ^ (xor_mode_r ? snk_data : 512'd0);
      end
      if (csr_read) begin
         csr_readdata_r <= rd_s;
      end
   end

   assign snk_ready    = final_s && xor_mode_r;
   assign st_valid     = st_valid_r;
   assign st_data      = st_data_r;
   assign csr_readdata = csr_readdata_r;

endmodule

// File: tb/tb_chacha_keystream.sv
// Self-checking bench for chacha_keystream: CSR vector table, RFC 8439 block,
// backpressure, counter wrap, XOR mode and abort cases, scored against a reference model.
module tb_chacha_keystream;

   localparam int ROUNDS = 20;

   logic         clock = 1'b0;
   logic         reset = 1'b1;
   logic         csr_write = 1'b0;
   logic         csr_read = 1'b0;
   logic [4:0]   csr_address = 5'd0;
   logic [31:0]  csr_writedata = 32'd0;
   logic [31:0]  rd1, rd2;
   logic [511:0] snk_data = '0;
   logic         snk_valid = 1'b0;
   logic         snk_ready1, snk_ready2;
   logic [511:0] st_data1, st_data2;
   logic         st_valid1, st_valid2;
   logic         st_ready = 1'b1;

   always #5 clock = ~clock;

   chacha_keystream #(.ROUNDS(20), .RPC(1)) dut (
      .clock(clock), .reset(reset),
      .csr_write(csr_write), .csr_read(csr_read), .csr_address(csr_address),
      .csr_writedata(csr_writedata), .csr_readdata(rd1),
      .snk_data(snk_data), .snk_valid(snk_valid), .snk_ready(snk_ready1),
      .st_data(st_data1), .st_valid(st_valid1), .st_ready(st_ready));

   chacha_keystream #(.ROUNDS(20), .RPC(2)) dut2 (
      .clock(clock), .reset(reset),
      .csr_write(csr_write), .csr_read(csr_read), .csr_address(csr_address),
      .csr_writedata(csr_writedata), .csr_readdata(rd2),
      .snk_data(snk_data), .snk_valid(snk_valid), .snk_ready(snk_ready2),
      .st_data(st_data2), .st_valid(st_valid2), .st_ready(st_ready));

   int errors = 0;
   int checks = 0;
   int delivered = 0;
   logic [511:0] exp_q[$];
   logic [31:0]  sh[16];
   logic         sh_ctr64 = 1'b0;
   logic [31:0]  rfc[16] = '{32'h61707865, 32'h3320646e, 32'h79622d32, 32'h6b206574,
                             32'h03020100, 32'h07060504, 32'h0b0a0908, 32'h0f0e0d0c,
                             32'h13121110, 32'h17161514, 32'h1b1a1918, 32'h1f1e1d1c,
                             32'h00000001, 32'h09000000, 32'h4a000000, 32'h00000000};

   typedef struct packed {
      logic        wr;
      logic [4:0]  addr;
      logic [31:0] wdata;
      logic [31:0] exp;
   } csr_vec_t;
   csr_vec_t tbl[8];

   task automatic check(input string name, input logic [511:0] act, input logic [511:0] expv);
      checks++;
      if (act !== expv) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, expv);
      end
   endtask

   function automatic logic [31:0] rl(input logic [31:0] v, input int n);
      return (v << n) | (v >> (32 - n));
   endfunction

   function automatic logic [511:0] ref_block(input logic [31:0] s[16]);
      logic [31:0]  x[16];
      logic [511:0] o;
      int           qi[8][4];
      qi = '{'{0, 4, 8, 12}, '{1, 5, 9, 13}, '{2, 6, 10, 14}, '{3, 7, 11, 15},
             '{0, 5, 10, 15}, '{1, 6, 11, 12}, '{2, 7, 8, 13}, '{3, 4, 9, 14}};
      x = s;
      for (int r = 0; r < ROUNDS; r++) begin
         for (int q = 0; q < 4; q++) begin
            int a, b, c, d;
            a = qi[(r % 2) * 4 + q][0];
            b = qi[(r % 2) * 4 + q][1];
            c = qi[(r % 2) * 4 + q][2];
            d = qi[(r % 2) * 4 + q][3];
            x[a] = x[a] + x[b]; x[d] = rl(x[d] ^ x[a], 16);
            x[c] = x[c] + x[d]; x[b] = rl(x[b] ^ x[c], 12);
            x[a] = x[a] + x[b]; x[d] = rl(x[d] ^ x[a], 8);
            x[c] = x[c] + x[d]; x[b] = rl(x[b] ^ x[c], 7);
         end
      end
      for (int i = 0; i < 16; i++) o[32*i +: 32] = x[i] + s[i];
      return o;
   endfunction

   task automatic advance();
      if (sh_ctr64 && sh[12] == 32'hffffffff) sh[13] = sh[13] + 32'd1;
      sh[12] = sh[12] + 32'd1;
   endtask

   task automatic push_blocks(input int n);
      for (int k = 0; k < n; k++) begin
         exp_q.push_back(ref_block(sh));
         advance();
      end
   endtask

   task automatic csr_wr(input logic [4:0] a, input logic [31:0] d);
      @(negedge clock);
      csr_write = 1'b1; csr_address = a; csr_writedata = d;
      @(negedge clock);
      csr_write = 1'b0;
   endtask

   task automatic csr_rd(input logic [4:0] a, output logic [31:0] d);
      @(negedge clock);
      csr_read = 1'b1; csr_address = a;
      @(negedge clock);
      csr_read = 1'b0;
      d = rd1;
   endtask

   task automatic load_rfc();
      for (int i = 0; i < 16; i++) begin
         sh[i] = rfc[i];
         csr_wr(5'(i), rfc[i]);
      end
   endtask

   task automatic wait_idle(input int lim);
      int n = 0;
      while (exp_q.size() != 0 && n < lim) begin
         @(negedge clock);
         n++;
      end
      check("queue_drained", 512'(exp_q.size()), 512'd0);
      repeat (3) @(negedge clock);
   endtask

   // Scoreboard monitor: checks held output under backpressure and every delivered block.
   logic         hold_pend = 1'b0;
   logic [511:0] hold_data;
   always @(negedge clock) begin
      #3;
      if (!reset) begin
         if (hold_pend) begin
            check("hold_valid", 512'(st_valid1), 512'd1);
            check("hold_data", st_data1, hold_data);
         end
         hold_pend = st_valid1 && !st_ready;
         hold_data = st_data1;
         if (st_valid1 && st_ready) begin
            delivered++;
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_block: got %0h expected no output", st_data1);
            end else begin
               check("block_data", st_data1, exp_q.pop_front());
            end
         end
      end else begin
         hold_pend = 1'b0;
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "timeout");
   end

   initial begin
      logic [31:0]  r;
      logic [511:0] e, d1, d2;
      int v1, v2, sr, sr2, sr_at, vcnt, base;

      tbl[0] = '{1'b0, 5'd17, 32'd0,          32'd0};
      tbl[1] = '{1'b0, 5'd18, 32'd0,          32'd0};
      tbl[2] = '{1'b0, 5'd16, 32'd0,          32'd0};
      tbl[3] = '{1'b1, 5'd5,  32'h12345678,   32'h12345678};
      tbl[4] = '{1'b1, 5'd19, 32'hdeadbeef,   32'hfb7e03d9};
      tbl[5] = '{1'b0, 5'd31, 32'd0,          32'hfb7e03d9};
      tbl[6] = '{1'b1, 5'd18, 32'd3,          32'd3};
      tbl[7] = '{1'b1, 5'd18, 32'd0,          32'd0};

      repeat (3) @(negedge clock);
      #1;
      check("reset_st_valid", 512'(st_valid1), 512'd0);
      check("reset_snk_ready", 512'(snk_ready1), 512'd0);
      reset = 1'b0;

      for (int i = 0; i < 8; i++) begin
         if (tbl[i].wr) csr_wr(tbl[i].addr, tbl[i].wdata);
         csr_rd(tbl[i].addr, r);
         check($sformatf("csr_vec%0d", i), 512'(r), 512'(tbl[i].exp));
      end

      // RFC 8439 block, both RPC variants in parallel
      load_rfc();
      e = ref_block(sh);
      push_blocks(1);
      csr_wr(5'd16, 32'd1);
      v1 = 0; v2 = 0; sr = 0;
      for (int n = 1; n <= 40; n++) begin
         @(negedge clock); #1;
         if (st_valid1 && v1 == 0) begin v1 = n; d1 = st_data1; end
         if (st_valid2 && v2 == 0) begin v2 = n; d2 = st_data2; end
         if (snk_ready1) sr++;
      end
      check("rfc_latency_rpc1", 512'(v1), 512'd20);
      check("rfc_latency_rpc2", 512'(v2), 512'd10);
      check("rfc_word0", 512'(d1[31:0]), 512'(32'he4e7f110));
      check("rfc_word15", 512'(d1[511:480]), 512'(32'h4e3c50a2));
      check("rfc_rpc2_data", d2, e);
      check("snk_ready_idle", 512'(sr), 512'd0);
      csr_rd(5'd12, r);
      check("rfc_ctr_after", 512'(r), 512'd2);
      check("rfc_ctr_after_rpc2", 512'(rd2), 512'd2);

      // Three blocks with st_ready held low until cycle 60
      base = delivered;
      st_ready = 1'b0;
      push_blocks(3);
      csr_wr(5'd16, 32'd3);
      repeat (56) @(negedge clock);
      csr_rd(5'd16, r);
      check("stall_pad", 512'(r), 512'd2);
      csr_rd(5'd17, r);
      check("stall_status", 512'(r), 512'(32'h113));
      st_ready = 1'b1;
      wait_idle(200);
      check("stall_delivered", 512'(delivered - base), 512'd3);

      // 64-bit counter carry, then 32-bit wrap without carry
      csr_wr(5'd18, 32'd2);
      sh_ctr64 = 1'b1; sh[12] = 32'hffffffff; sh[13] = 32'h5;
      csr_wr(5'd12, sh[12]);
      csr_wr(5'd13, sh[13]);
      push_blocks(1);
      csr_wr(5'd16, 32'd1);
      wait_idle(60);
      csr_rd(5'd12, r);
      check("ctr64_w12", 512'(r), 512'd0);
      csr_rd(5'd13, r);
      check("ctr64_w13", 512'(r), 512'd6);
      csr_wr(5'd18, 32'd0);
      sh_ctr64 = 1'b0; sh[12] = 32'hffffffff; sh[13] = 32'h5;
      csr_wr(5'd12, sh[12]);
      csr_wr(5'd13, sh[13]);
      push_blocks(1);
      csr_wr(5'd16, 32'd1);
      wait_idle(60);
      csr_rd(5'd12, r);
      check("ctr32_w12", 512'(r), 512'd0);
      csr_rd(5'd13, r);
      check("ctr32_w13", 512'(r), 512'd5);

      // XOR mode with zero plaintext arriving 5 cycles late
      load_rfc();
      csr_wr(5'd18, 32'd1);
      push_blocks(1);
      csr_wr(5'd16, 32'd1);
      v1 = 0; sr = 0; sr2 = 0; sr_at = 0;
      for (int n = 1; n <= 40; n++) begin
         @(negedge clock);
         if (n == 24) snk_valid = 1'b1;
         if (n == 25) snk_valid = 1'b0;
         #1;
         if (snk_ready1) begin sr++; sr_at = n; end
         if (snk_ready2) sr2++;
         if (st_valid1 && v1 == 0) begin v1 = n; d1 = st_data1; end
      end
      check("xor_snk_ready_pulses", 512'(sr), 512'd1);
      check("xor_snk_ready_cycle", 512'(sr_at), 512'd24);
      check("xor_snk_ready_rpc2", 512'(sr2), 512'd1);
      check("xor_valid_cycle", 512'(v1), 512'd25);
      check("xor_word0", 512'(d1[31:0]), 512'(32'he4e7f110));
      csr_wr(5'd18, 32'd0);
      wait_idle(20);

      // Pad counter rewritten at round 7 aborts the block
      csr_wr(5'd16, 32'd1);
      advance();
      repeat (6) @(negedge clock);
      push_blocks(1);
      csr_wr(5'd16, 32'd1);
      v1 = 0;
      for (int n = 1; n <= 30; n++) begin
         @(negedge clock); #1;
         if (st_valid1 && v1 == 0) v1 = n;
      end
      check("abort_restart_latency", 512'(v1), 512'd20);
      wait_idle(20);

      // Reset at round 5 aborts the block with no output
      csr_wr(5'd18, 32'd2);
      csr_wr(5'd16, 32'd1);
      advance();
      repeat (5) @(negedge clock);
      reset = 1'b1;
      @(negedge clock);
      reset = 1'b0;
      vcnt = 0;
      for (int n = 0; n < 30; n++) begin
         @(negedge clock); #1;
         if (st_valid1) vcnt++;
      end
      check("reset_abort_no_valid", 512'(vcnt), 512'd0);
      csr_rd(5'd16, r);
      check("reset_abort_pad", 512'(r), 512'd0);
      csr_rd(5'd17, r);
      check("reset_abort_status", 512'(r), 512'd0);
      csr_rd(5'd18, r);
      check("reset_abort_ctrl", 512'(r), 512'd0);
      csr_rd(5'd12, r);
      check("reset_abort_ctr", 512'(r), 512'(sh[12]));
      sh_ctr64 = 1'b0;
      push_blocks(1);
      csr_wr(5'd16, 32'd1);
      v1 = 0;
      for (int n = 1; n <= 30; n++) begin
         @(negedge clock); #1;
         if (st_valid1 && v1 == 0) v1 = n;
      end
      check("reset_restart_latency", 512'(v1), 512'd20);
      wait_idle(20);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
